// File: rtl/xor_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xor_unit_pkg
// Purpose : Shared operation encoding for the pipelined XOR unit.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package xor_unit_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_XOR    = 2'd0;
  localparam op_t OP_XNOR   = 2'd1;
  localparam op_t OP_PARITY = 2'd2;
  localparam op_t OP_ACCUM  = 2'd3;

endpackage : xor_unit_pkg
`default_nettype wire

// File: rtl/xor_unit_stage.sv
`default_nettype none
// ============================================================================
// Module  : xor_unit_stage
// Purpose : One valid/ready pipeline register with a WIDTH-bit payload.
//           Loads whenever it is empty or its content is being taken.
// Ports   : clk, rst        - clock, async active-high reset
//           in_valid/ready  - upstream handshake, in_data payload
//           out_valid/ready - downstream handshake, out_data payload
// Revision: 1.0 - initial release
// ============================================================================
module xor_unit_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Ready when empty or when the held item leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule : xor_unit_stage
`default_nettype wire

// File: rtl/xor_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : xor_unit_pipe
// Purpose : Two-stage pipelined XOR unit with XOR / XNOR / parity / running
//           accumulator modes under valid/ready flow control.
// Ports   : clk, rst               - clock, async active-high reset
//           in_valid, in_ready     - input handshake
//           a, b, op               - operands and mode
//           clr                    - synchronous accumulator clear
//           out_valid, out_ready   - output handshake
//           result                 - computed value
//           acc_q                  - current accumulator contents
// Revision: 1.0 - initial release
// ============================================================================
module xor_unit_pipe
  import xor_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_q
);

  localparam int S1W = 3 * WIDTH + 2;

  logic             accept;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] acc_next;
  logic [S1W-1:0]   s1_in;
  logic [S1W-1:0]   s1_data;
  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_acc;
  logic [WIDTH-1:0] s2_in;

  assign accept = in_valid && in_ready;

  // The accumulator advances at accept time so back-to-back ACCUMs chain
  // without forwarding; clear is applied before the transaction's XOR.
  assign acc_base = clr ? ACC_INIT : acc_q;
  assign acc_next = (accept && (op == OP_ACCUM)) ? (acc_base ^ a) : acc_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= ACC_INIT;
    end else begin
      acc_q <= acc_next;
    end
  end

  // S1 snapshots the post-update accumulator so the ACCUM result is fixed
  // at accept time, independent of later accepts or clears.
  assign s1_in = {a, b, op, acc_next};

  xor_unit_stage #(.WIDTH(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_a   = s1_data[S1W-1 -: WIDTH];
  assign s1_b   = s1_data[2*WIDTH+1 -: WIDTH];
  assign s1_op  = s1_data[WIDTH+1 -: 2];
  assign s1_acc = s1_data[WIDTH-1:0];

  always_comb begin
    s2_in = '0;
    unique case (s1_op)
      OP_XOR:    s2_in = s1_a ^ s1_b;
      OP_XNOR:   s2_in = ~(s1_a ^ s1_b);
      // Indexed assignment keeps WIDTH=1 legal (no zero-width replication).
      OP_PARITY: s2_in[0] = ^(s1_a ^ s1_b);
      default:   s2_in = s1_acc;
    endcase
  end

  xor_unit_stage #(.WIDTH(WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (result)
  );

endmodule : xor_unit_pipe
`default_nettype wire

// File: tb/tb_xor_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_xor_unit_pipe
// Purpose : Self-checking bench for xor_unit_pipe (WIDTH=8, ACC_INIT=0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_xor_unit_pipe;
  import xor_unit_pkg::*;

  localparam int         W        = 8;
  localparam logic [7:0] ACC_INIT = 8'h00;
  localparam int         NV       = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  op_t        op;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] acc_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_acc;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    op_t        op;
    logic       clr;
    logic [7:0] exp_res;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t tab[NV];

  xor_unit_pipe #(.WIDTH(W), .ACC_INIT(ACC_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .acc_q     (acc_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the mode definitions.
  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input op_t o, input logic [7:0] accv);
    case (o)
      OP_XOR:    return x ^ y;
      OP_XNOR:   return ~(x ^ y);
      OP_PARITY: return {7'd0, ^(x ^ y)};
      default:   return accv;
    endcase
  endfunction

  // One clock cycle, entered and left at a falling edge. Handshakes are
  // sampled shortly before the rising edge; the model follows them.
  task automatic step(output bit fired);
    logic [7:0] base;
    #4;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %0h expected no output", result);
      end else begin
        chk("result_order", 32'(result), 32'(exp_q.pop_front()));
      end
    end
    base = clr ? ACC_INIT : m_acc;
    if (fired) begin
      if (op == OP_ACCUM) base = base ^ a;
      exp_q.push_back(ref_op(a, b, op, base));
    end
    m_acc = base;
    @(posedge clk);
    #1;
    chk("acc_model", 32'(acc_q), 32'(m_acc));
    @(negedge clk);
  endtask

  initial begin
    bit         f;
    int         idx;
    logic [7:0] bp[4];

    tab[0] = '{8'hA5, 8'h0F, OP_XOR,    1'b0, 8'hAA, 8'h00};
    tab[1] = '{8'hA5, 8'h0F, OP_XNOR,   1'b0, 8'h55, 8'h00};
    tab[2] = '{8'h07, 8'h00, OP_PARITY, 1'b0, 8'h01, 8'h00};
    tab[3] = '{8'h03, 8'h00, OP_PARITY, 1'b0, 8'h00, 8'h00};
    tab[4] = '{8'h11, 8'hEE, OP_ACCUM,  1'b0, 8'h11, 8'h11};
    tab[5] = '{8'h22, 8'h99, OP_ACCUM,  1'b0, 8'h33, 8'h33};
    tab[6] = '{8'h11, 8'h00, OP_ACCUM,  1'b0, 8'h22, 8'h22};
    tab[7] = '{8'h11, 8'h00, OP_ACCUM,  1'b0, 8'h33, 8'h33};
    tab[8] = '{8'h0C, 8'h77, OP_ACCUM,  1'b1, 8'h0C, 8'h0C};
    tab[9] = '{8'hFF, 8'hF0, OP_XOR,    1'b0, 8'h0F, 8'h0C};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    a = '0; b = '0; op = OP_XOR; m_acc = ACC_INIT;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_acc_q",     32'(acc_q),     32'(ACC_INIT));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Table vectors, one per cycle at full throughput
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      a = tab[i].a; b = tab[i].b; op = tab[i].op; clr = tab[i].clr;
      step(f);
      chk("tab_accept", 32'(f), 32'd1);
      chk("tab_acc_q", 32'(acc_q), 32'(tab[i].exp_acc));
      if (i == 0) begin
        chk("tab_first_latency", 32'(out_valid), 32'd0);
      end else begin
        chk("tab_out_valid", 32'(out_valid), 32'd1);
        chk("tab_result", 32'(result), 32'(tab[i-1].exp_res));
      end
    end
    in_valid = 1'b0; clr = 1'b0;
    step(f);
    chk("tab_result_last", 32'(result), 32'(tab[NV-1].exp_res));

    // Clear without a transaction
    clr = 1'b1; op = OP_ACCUM; a = 8'hFF;
    step(f);
    chk("clr_alone", 32'(acc_q), 32'(ACC_INIT));
    clr = 1'b0;
    repeat (2) step(f);

    // Backpressure: four XORs with the consumer stalled for a while
    bp[0] = 8'h12; bp[1] = 8'h34; bp[2] = 8'h56; bp[3] = 8'h78;
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid = 1'b1; a = bp[idx]; b = 8'h0F; op = OP_XOR; clr = 1'b0;
      step(f);
      if (f) idx++;
      if (c >= 1 && c < 5) begin
        chk("bp_in_ready_low", 32'(in_ready),  32'd0);
        chk("bp_accepts",      32'(idx),       32'd2);
        chk("bp_out_valid",    32'(out_valid), 32'd1);
        chk("bp_result_hold",  32'(result),    32'(8'h12 ^ 8'h0F));
      end
    end
    chk("bp_all_sent", 32'(idx), 32'd4);
    in_valid = 1'b0;
    repeat (4) step(f);
    chk("bp_none_lost", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h5A; b = 8'h00; op = OP_ACCUM;
    step(f);
    chk("ar_accept0", 32'(f), 32'd1);
    a = 8'h01; b = 8'h02; op = OP_XOR;
    step(f);
    chk("ar_accept1", 32'(f), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_acc_q",     32'(acc_q),     32'(ACC_INIT));
    #1 rst = 1'b0;
    exp_q.delete();
    m_acc = ACC_INIT;
    @(negedge clk);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h3C; b = 8'hC3; op = OP_XOR;
    step(f);
    chk("ar_post_accept", 32'(f), 32'd1);
    chk("ar_post_lat1", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    step(f);
    chk("ar_post_lat2", 32'(out_valid), 32'd1);
    chk("ar_post_result", 32'(result), 32'hFF);
    step(f);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 8'($urandom);
      b   = 8'($urandom);
      op  = op_t'($urandom_range(0, 3));
      clr = ($urandom_range(0, 9) == 0);
      step(f);
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) step(f);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xor_unit_pipe
`default_nettype wire
